// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared decode types, opcode-field constants and FSM state enum.
package Definitions;
    typedef enum logic [2:0] {
        ADD = 3'b010,
        SUB = 3'b011,
        XOR = 3'b100,
        AND = 3'b101,
        LSL = 3'b110,
        MOV = 3'b111
    } op_mne;

    localparam logic [2:0] OP_LDI  = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b001;
    localparam int OPC_W = 3;
    localparam int REG_W = 3;
    localparam int IMM_W = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [OPC_W-1:0] alu_op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [IMM_W-1:0] imm;
        logic             imm_sel;
    } bundle_t;

    localparam bundle_t BUNDLE_RST = '{ADD, 3'd0, 3'd0, 3'd0, 1'b0};
endpackage

// File: rtl/decode_stage_skid_buf.sv
// skid_buf: 2-entry FIFO of decoded bundles; head stays put when the buffer drains empty.
module skid_buf
    import Definitions::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  bundle_t din,
    output bundle_t head,
    output logic    valid,
    output logic    full
);
    logic [1:0] count;
    logic [1:0] wr_idx;
    logic       do_push;
    logic       do_pop;
    bundle_t    mem1;

    assign valid   = count != 2'd0;
    assign full    = count == 2'd2;
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign wr_idx  = count - {1'b0, do_pop};

    // the slot written is the one left free after this cycle's pop shifts the queue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= BUNDLE_RST;
            mem1  <= BUNDLE_RST;
        end else begin
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
            if (do_pop && full) head <= mem1;
            if (do_push && wr_idx == 2'd0) head <= din;
            if (do_push && wr_idx == 2'd1) mem1 <= din;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes fetched instructions into ALU bundles through a 2-entry skid buffer,
// with a run/drain/halt control FSM and a saturating retired-bundle counter.
module decode_stage
    import Definitions::*;
#(
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] InstrIn,
    input  logic               InValid,
    output logic               InReady,
    output logic [2:0]         AluOp,
    output logic [2:0]         Rd,
    output logic [2:0]         Rs,
    output logic [2:0]         Imm,
    output logic               ImmSel,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               Done,
    output logic [CNT_W-1:0]   InstrCount
);
    state_t     state, state_nx;
    bundle_t    dec, head;
    logic [2:0] opcode;
    logic       is_ldi, is_halt, accept, push, pop, buf_valid, buf_full;

    assign opcode  = InstrIn[8:6];
    assign is_ldi  = opcode == OP_LDI;
    assign is_halt = opcode == OP_HALT;
    assign InReady = state == RUN && !buf_full;
    assign accept  = InValid && InReady;
    assign push    = accept && !is_halt;
    assign pop     = buf_valid && OutReady;

    always_comb begin
        dec.alu_op  = is_ldi ? MOV : opcode;
        dec.rd      = InstrIn[5:3];
        dec.rs      = is_ldi ? 3'd0 : InstrIn[2:0];
        dec.imm     = is_ldi ? InstrIn[2:0] : 3'd0;
        dec.imm_sel = is_ldi;
    end

    skid_buf u_skid_buf (
        .clk  (Clk),
        .rst_n(Reset),
        .push (push),
        .pop  (pop),
        .din  (dec),
        .head (head),
        .valid(buf_valid),
        .full (buf_full)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else state <= state_nx;
    end

    // DRAIN ends on the edge where the last buffered bundle leaves
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE || state == HALTED) ? (Start ? RUN : state)
                 : (state == RUN) ? ((accept && is_halt) ? DRAIN : RUN)
                 : (!buf_valid || (pop && !buf_full)) ? HALTED : DRAIN;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) InstrCount <= '0;
        else if (state == HALTED && Start) InstrCount <= '0;
        else if (pop && InstrCount != '1) InstrCount <= InstrCount + CNT_W'(1);
    end

    assign AluOp    = head.alu_op;
    assign Rd       = head.rd;
    assign Rs       = head.rs;
    assign Imm      = head.imm;
    assign ImmSel   = head.imm_sel;
    assign OutValid = buf_valid;
    assign Done     = state == HALTED;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus checked every cycle against a queue-based model.
module tb_decode_stage;
    logic        Clk = 1'b0;
    logic        Reset, Start, InValid, OutReady;
    logic [8:0]  InstrIn;
    logic        InReady, ImmSel, OutValid, Done;
    logic [2:0]  AluOp, Rd, Rs, Imm;
    logic [15:0] InstrCount;

    always #5 Clk = ~Clk;

    decode_stage #(.INSTR_W(9), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InstrIn(InstrIn), .InValid(InValid),
        .InReady(InReady), .AluOp(AluOp), .Rd(Rd), .Rs(Rs), .Imm(Imm), .ImmSel(ImmSel),
        .OutValid(OutValid), .OutReady(OutReady), .Done(Done), .InstrCount(InstrCount)
    );

    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_HALTED = 3;
    localparam logic [12:0] RST_BUNDLE = 13'b010_000_000_000_0;

    int          checks = 0;
    int          errors = 0;
    int          mst = S_IDLE;
    int          mcnt = 0;
    logic [12:0] q[$];
    logic [12:0] last = RST_BUNDLE;
    bit          armed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bundle packed as {alu, rd, rs, imm, sel}
    function automatic logic [12:0] expect_bundle(input logic [8:0] i);
        logic [2:0] op;
        op = i[8:6];
        if (op == 3'd0) return {3'd7, i[5:3], 3'd0, i[2:0], 1'b1};
        return {op, i[5:3], i[2:0], 3'd0, 1'b0};
    endfunction

    task automatic cyc(input logic r, input logic s, input logic v, input logic [8:0] i, input logic o);
        bit rdy, acc, hs;
        @(negedge Clk);
        if (armed) begin
            chk("in_ready", InReady, mst == S_RUN && q.size() < 2);
            chk("out_valid", OutValid, q.size() != 0);
            chk("done", Done, mst == S_HALTED);
            chk("count", InstrCount, mcnt);
            chk("bundle", {AluOp, Rd, Rs, Imm, ImmSel}, q.size() != 0 ? q[0] : last);
        end
        Reset = r; Start = s; InValid = v; InstrIn = i; OutReady = o;
        if (!r) begin
            mst = S_IDLE; q.delete(); last = RST_BUNDLE; mcnt = 0;
        end else begin
            rdy = mst == S_RUN && q.size() < 2;
            acc = v && rdy;
            hs  = q.size() != 0 && o;
            if (hs) begin
                last = q.pop_front();
                if (mcnt < 65535) mcnt++;
            end
            case (mst)
                S_IDLE:   if (s) mst = S_RUN;
                S_RUN:    if (acc && i[8:6] == 3'd1) mst = S_DRAIN; else if (acc) q.push_back(expect_bundle(i));
                S_DRAIN:  if (q.size() == 0) mst = S_HALTED;
                default:  if (s) begin mst = S_RUN; mcnt = 0; end
            endcase
        end
        armed = 1'b1;
    endtask

    function automatic logic [8:0] rnd_instr();
        logic [8:0] x;
        x = 9'($urandom);
        if (x[8:6] == 3'd1 && $urandom % 4 != 0) x[8:6] = 3'd2;
        return x;
    endfunction

    initial begin
        logic [8:0] pi;
        bit pv, took, r, s, o;
        pv = 0; pi = '0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_alu", AluOp, 3'b010);
        chk("rst_in_ready", InReady, 0);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 1, 9'b010_001_010, 1);
        cyc(1, 0, 1, 9'b000_011_101, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("ldi_imm", Imm, 5);
        chk("ldi_sel", ImmSel, 1);
        chk("ldi_alu", AluOp, 3'b111);
        chk("ldi_rd", Rd, 3);
        chk("cnt_after_two", InstrCount, 2);
        cyc(1, 0, 1, 9'b011_010_001, 0);
        cyc(1, 0, 1, 9'b100_100_110, 0);
        cyc(1, 0, 1, 9'b101_111_000, 0);
        chk("full_in_ready", InReady, 0);
        chk("full_hold_alu", AluOp, 3'b011);
        cyc(1, 0, 1, 9'b101_111_000, 1);
        cyc(1, 0, 1, 9'b101_111_000, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("cnt_after_five", InstrCount, 5);
        cyc(1, 0, 1, 9'b110_001_001, 0);
        cyc(1, 0, 1, 9'b001_000_000, 0);
        cyc(1, 0, 1, 9'b010_010_010, 0);
        chk("drain_in_ready", InReady, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("halt_done", Done, 1);
        chk("halt_cnt", InstrCount, 6);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("restart_cnt", InstrCount, 0);
        chk("restart_done", Done, 0);
        cyc(1, 0, 1, 9'b111_001_010, 0);
        cyc(1, 0, 1, 9'b011_100_101, 0);
        cyc(0, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("rst_mid_valid", OutValid, 0);
        chk("rst_mid_in_ready", InReady, 0);
        chk("rst_mid_cnt", InstrCount, 0);
        cyc(1, 1, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            if (!pv) begin pv = ($urandom % 10) < 7; pi = rnd_instr(); end
            r = ($urandom % 64) != 0;
            s = ($urandom % 16) == 0;
            o = ($urandom % 10) < 6;
            took = pv && r && mst == S_RUN && q.size() < 2;
            cyc(r, s, pv, pi, o);
            if (took) pv = 0;
        end
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        for (int n = 0; n < 65540; n++) cyc(1, 0, 1, 9'b010_000_000, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("saturated", InstrCount, 16'hFFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter INSTR_W, 9, instruction width in bits.
REQ-002 Parameter CNT_W, 16, width of the retired-instruction counter.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low; low at a rising Clk edge resets the block.
REQ-005 Start  input  1  single-cycle pulse; leaves IDLE/HALTED.
REQ-006 InstrIn  input  INSTR_W  instruction from fetch; [8:6] opcode field, [5:3] Rd, [2:0] Rs/imm.
REQ-007 InValid  input  1  InstrIn valid.
REQ-008 InReady  output  1  block accepts InstrIn this cycle.
REQ-009 AluOp  output  3  op_mne value for the ALU.
REQ-010 Rd, Rs  output  3 each  register addresses.
REQ-011 Imm  output  3  zero-extended immediate; ImmSel  output  1  selects Imm over Rs.
REQ-012 OutValid  output  1  decoded bundle valid; OutReady  input  1  ALU stage consumes it.
REQ-013 Done  output  1  high only in HALTED.
REQ-014 InstrCount  output  CNT_W  count of bundles handed to the ALU.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN, HALTED; Reset -> IDLE.
REQ-016 IDLE: Start -> RUN; InReady=0.
REQ-017 RUN: InReady=1 iff skid buffer occupancy <2 at cycle start; accept on InValid&&InReady.
REQ-018 Opcode 000 (LDI): AluOp=MOV, ImmSel=1, Imm=InstrIn[2:0], Rs=0.
REQ-019 Opcode 001 (HALT): not enqueued; FSM RUN -> DRAIN; InReady=0 from the next cycle.
REQ-020 Opcodes 010..111: AluOp=opcode field unchanged (ADD, SUB, XOR, AND, LSL, MOV), ImmSel=0, Imm=0.
REQ-021 Decoded bundles pass through a 2-entry FIFO-ordered skid buffer; head drives outputs.
REQ-022 Latency: bundle accepted in cycle N with empty buffer shows OutValid=1 in cycle N+1.
REQ-023 While OutValid&&!OutReady, AluOp, Rd, Rs, Imm and ImmSel hold stable.
REQ-024 Push and pop in the same cycle: occupancy unchanged, order preserved.
REQ-025 Full buffer: InReady=0; no instruction dropped or duplicated.
REQ-026 DRAIN: remaining entries emitted normally; when occupancy reaches 0, DRAIN -> HALTED.
REQ-027 HALTED: Done=1, InReady=0; Start -> RUN and clears InstrCount.
REQ-028 Start in RUN or DRAIN is ignored.
REQ-029 InstrCount increments on each OutValid&&OutReady and saturates at all-ones.
REQ-030 OutValid=0 whenever the buffer is empty; outputs then hold last value.

Reset
REQ-031 On Reset low: state=IDLE, buffer flushed, InReady=0, OutValid=0, AluOp=ADD (3'b010), Rd=Rs=Imm=0, ImmSel=0, Done=0, InstrCount=0.
REQ-032 Reset mid-operation discards buffered bundles with no output handshake; Reset takes priority over Start.

Structure
REQ-033 Package Definitions adds opcode-field constants OP_LDI=3'b000 and OP_HALT=3'b001, field widths, and the FSM state enum; op_mne stays unchanged.
REQ-034 The 2-entry buffer is sub-module skid_buf; decode logic and FSM stay in decode_stage.

Verification
REQ-035 Reset, Start, then InstrIn=9'b010_001_010 with OutReady=1 -> next cycle OutValid=1, AluOp=ADD, Rd=1, Rs=2, ImmSel=0; InstrCount=1.
REQ-036 InstrIn=9'b000_011_101 -> AluOp=MOV, ImmSel=1, Imm=5, Rd=3.
REQ-037 OutReady=0 and 3 back-to-back instructions -> two accepted, InReady=0 on the third, outputs stable; release OutReady -> all in order, count=3.
REQ-038 HALT with 2 buffered -> InReady=0, both emitted, Done=1 next cycle; Start -> RUN, InstrCount=0.
REQ-039 Reset low with 2 buffered -> OutValid=0 next cycle, InstrCount=0, state IDLE, Start ignored while Reset low.
REQ-040 Force InstrCount to 16'hFFFF -> further handshakes leave 16'hFFFF.
